// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 16x-oversampled UART receiver (majority vote, parity/stop checks)
//            feeding a show-ahead receive FIFO with sticky overrun flag.
//            Optional break detection: define UART_RX_BREAK_DETECT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_LEN   = 8,
    parameter int PARITY_BIT = 0,
    parameter int STOP_BIT   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        rd_en,
    output logic [DATA_LEN-1:0]         rd_data,
    output logic                        rd_parity_err,
    output logic                        rd_frame_err,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        break_det
);

    localparam int c_BAUD_OS = BAUD_RATE * OVERSAMPLE;
    localparam int c_DIV_RAW = (CLK_FREQ + c_BAUD_OS / 2) / c_BAUD_OS;
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_DIV_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SC_W    = $clog2(OVERSAMPLE);
    localparam int c_BIT_W   = $clog2(DATA_LEN);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_EW      = DATA_LEN + 2;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_SC_W-1:0]  c_SC_LO    = c_SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SC_W-1:0]  c_SC_CTR   = c_SC_W'(OVERSAMPLE / 2);
    localparam logic [c_SC_W-1:0]  c_SC_HI    = c_SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_SC_W-1:0]  c_SC_MAX   = c_SC_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_LEN - 1);
    localparam logic               c_LAST_STP = 1'(STOP_BIT - 1);
    localparam logic [c_AW:0]      c_FULL_CNT = FIFO_DEPTH[c_AW:0];

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] c_ST_BREAK  = 3'd5;
`endif

    logic [1:0]          r_sync;
    logic                r_rxs_d;
    logic                w_rxs;
    logic                w_fall;
    logic [c_DIV_W-1:0]  r_div;
    logic                w_tick;
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_SC_W-1:0]   r_sc;
    logic                r_smp_a;
    logic                r_smp_b;
    logic                w_maj;
    logic                w_mid;
    logic                w_last_stop;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_stop_cnt;
    logic [DATA_LEN-1:0] r_shift;
    logic                r_par_acc;
    logic                r_par_err;
    logic                r_frame_err;
    logic                w_par_calc;
    logic                w_par_err_nxt;
    logic                w_frame_err_nxt;
    logic                w_push_req;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                r_all_zero;
    logic                w_is_break;
    logic                w_break_evt;
    logic                r_break_det;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_rxs_d <= r_sync[1];
        end
    end

    assign w_rxs  = r_sync[1];
    assign w_fall = r_rxs_d & ~w_rxs;

    // Divider is realigned to the start edge so sample phase tracks the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (((r_state == c_ST_IDLE) && w_fall) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = (r_div == c_DIV_LAST);

    assign w_maj = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
    assign w_mid = w_tick && (r_sc == c_SC_HI) &&
                   ((r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                    (r_state == c_ST_PARITY) || (r_state == c_ST_STOP));
    assign w_last_stop = w_mid && (r_state == c_ST_STOP) && (r_stop_cnt == c_LAST_STP);

    assign w_par_calc      = r_par_acc ^ w_maj;
    assign w_par_err_nxt   = (PARITY_BIT == 1) ? ~w_par_calc :
                             (PARITY_BIT == 2) ?  w_par_calc : 1'b0;
    assign w_frame_err_nxt = r_frame_err | ~w_maj;
`ifdef UART_RX_BREAK_DETECT_EN
    assign w_is_break = r_all_zero & ~w_maj;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_fall) w_state_nxt = c_ST_START;
            c_ST_START:  if (w_mid) w_state_nxt = w_maj ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:   if (w_mid && (r_bit_cnt == c_LAST_BIT))
                             w_state_nxt = (PARITY_BIT != 0) ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_mid) w_state_nxt = c_ST_STOP;
            c_ST_STOP: begin
                if (w_last_stop) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    w_state_nxt = w_is_break ? c_ST_BREAK : c_ST_IDLE;
`else
                    w_state_nxt = c_ST_IDLE;
`endif
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            c_ST_BREAK:  if (w_tick && w_rxs && (r_sc == c_SC_MAX)) w_state_nxt = c_ST_IDLE;
`endif
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_push_req = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        w_break_evt = 1'b0;
        if (w_last_stop) begin
            if (w_is_break) w_break_evt = 1'b1;
            else            w_push_req  = 1'b1;
        end
`else
        if (w_last_stop) w_push_req = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc        <= '0;
            r_smp_a     <= 1'b1;
            r_smp_b     <= 1'b1;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_all_zero  <= 1'b0;
`endif
        end else if ((r_state == c_ST_IDLE) && w_fall) begin
            r_sc        <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_all_zero  <= 1'b1;
`endif
        end else if (w_tick) begin
            if (r_sc == c_SC_LO)  r_smp_a <= w_rxs;
            if (r_sc == c_SC_CTR) r_smp_b <= w_rxs;
            r_sc <= (r_sc == c_SC_MAX) ? '0 : r_sc + 1'b1;
            if (w_mid) begin
                case (r_state)
                    c_ST_DATA: begin
                        r_shift   <= {w_maj, r_shift[DATA_LEN-1:1]};
                        r_par_acc <= r_par_acc ^ w_maj;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    c_ST_PARITY: r_par_err <= w_par_err_nxt;
                    c_ST_STOP: begin
                        r_frame_err <= w_frame_err_nxt;
                        r_stop_cnt  <= r_stop_cnt + 1'b1;
                    end
                    default: ;
                endcase
`ifdef UART_RX_BREAK_DETECT_EN
                if (r_state != c_ST_START) r_all_zero <= r_all_zero & ~w_maj;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            // In BREAK the sample counter measures the run of idle-high ticks
            if (r_state == c_ST_BREAK) r_sc <= w_rxs ? r_sc + 1'b1 : '0;
            if (w_break_evt)           r_sc <= '0;
`endif
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_break_det <= 1'b0;
        end else begin
            r_break_det <= w_break_evt;
        end
    end
    assign break_det = r_break_det;
`else
    assign break_det = 1'b0;
`endif

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overrun;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_ovr_set;
    logic [c_EW-1:0] w_head;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovr_set = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_frame_err_nxt, r_par_err, r_shift};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovr_set)        r_overrun <= 1'b1;
            else if (clr_overrun) r_overrun <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rd_data       = w_head[DATA_LEN-1:0];
    assign rd_parity_err = w_head[DATA_LEN];
    assign rd_frame_err  = w_head[DATA_LEN+1];
    assign empty         = w_empty;
    assign full          = w_full;
    assign count         = r_count;
    assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames against a queue-level FIFO model,
// plus a second instance configured for even parity.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

    localparam int c_DEPTH = 4;
    localparam int c_BIT   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       rx = 1'b1, rd_en = 1'b0, clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_parity_err, rd_frame_err, empty, full, overrun, break_det;
    logic [2:0] count;

    logic       rx_p = 1'b1, rd_en_p = 1'b0, clr_p = 1'b0;
    logic [7:0] rd_data_p;
    logic       rd_parity_err_p, rd_frame_err_p, empty_p, full_p, overrun_p, break_det_p;
    logic [2:0] count_p;

    uart_rx_fifo #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16), .DATA_LEN(8),
        .PARITY_BIT(0), .STOP_BIT(1), .FIFO_DEPTH(c_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .clr_overrun(clr_overrun),
        .break_det(break_det)
    );

    uart_rx_fifo #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16), .DATA_LEN(8),
        .PARITY_BIT(2), .STOP_BIT(1), .FIFO_DEPTH(c_DEPTH)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_p),
        .rd_parity_err(rd_parity_err_p), .rd_frame_err(rd_frame_err_p), .empty(empty_p),
        .full(full_p), .count(count_p), .overrun(overrun_p), .clr_overrun(clr_p),
        .break_det(break_det_p)
    );

    int         n_err = 0;
    int         n_chk = 0;
    logic [9:0] m_q[$];          // entries {frame_err, parity_err, data}
    logic       m_ovr = 1'b0;
    logic       quiet = 1'b0;
    int         brk_cnt = 0;
    logic [9:0] head;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model compare, only while no frame is on the line
    always @(negedge clk) begin
        if (break_det) brk_cnt++;
        if (quiet) begin
            chk("m_empty", empty, m_q.size() == 0);
            chk("m_full", full, m_q.size() == c_DEPTH);
            chk("m_count", count, m_q.size());
            chk("m_overrun", overrun, m_ovr);
            chk("m_break_det", break_det, 0);
            if (m_q.size() > 0) begin
                head = m_q[0];
                chk("m_rd_data", rd_data, head[7:0]);
                chk("m_rd_parity_err", rd_parity_err, head[8]);
                chk("m_rd_frame_err", rd_frame_err, head[9]);
            end
        end
    end

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stopb);
        return {6'b111111, stopb, d, 1'b0};
    endfunction

    task automatic send(input logic line, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (line) rx_p = bits[i];
            else      rx   = bits[i];
            repeat (c_BIT) @(posedge clk);
            #2;
        end
        if (line) rx_p = 1'b1;
        else      rx   = 1'b1;
    endtask

    task automatic model_frame(input logic [9:0] e, input logic simpop);
        if (simpop && m_q.size() != 0) m_q.delete(0);
        if (m_q.size() < c_DEPTH) m_q.push_back(e);
        else                      m_ovr = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stopb);
        quiet = 1'b0;
        send(1'b0, f8n1(d, stopb), 10);
        model_frame({~stopb, 1'b0, d}, 1'b0);
        quiet = 1'b1;
    endtask

    task automatic pop(input logic [7:0] expd);
        chk("pop_head", rd_data, expd);
        rd_en = 1'b1;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        if (m_q.size() > 0) m_q.delete(0);
    endtask

    task automatic pop_p();
        rd_en_p = 1'b1;
        @(posedge clk);
        #2;
        rd_en_p = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_parity_err", rd_parity_err, 0);
        chk("rst_frame_err", rd_frame_err, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_break_det", break_det, 0);
        chk("rst_empty_p", empty_p, 1);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        quiet = 1'b1;

        rx_frame(8'hA5, 1'b1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_count", count, 1);
        chk("a5_flags", {rd_frame_err, rd_parity_err}, 0);
        pop(8'hA5);
        chk("a5_empty", empty, 1);

        rx_frame(8'h3C, 1'b0);
        chk("fe_flag", rd_frame_err, 1);
        chk("fe_data", rd_data, 8'h3C);
        pop(8'h3C);

        for (int i = 1; i <= 5; i++) begin
            rx_frame(8'(i), 1'b1);
            if (i == 4) chk("full_4th", full, 1);
        end
        chk("ovr_set", overrun, 1);
        for (int i = 1; i <= 4; i++) pop(8'(i));
        chk("drained", empty, 1);
        clr_overrun = 1'b1;
        @(posedge clk);
        #2;
        clr_overrun = 1'b0;
        m_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        quiet = 1'b0;
        rx = 1'b0;
        repeat (c_BIT / 4) @(posedge clk);
        #2;
        rx = 1'b1;
        repeat (3 * c_BIT) @(posedge clk);
        #2;
        quiet = 1'b1;
        chk("glitch_empty", empty, 1);

        for (int i = 0; i < 4; i++) rx_frame(8'h10 + 8'(i), 1'b1);
        chk("pre_sim_full", full, 1);
        quiet = 1'b0;
        // Push lands on the 157th edge after the start bit is driven
        fork
            send(1'b0, f8n1(8'h14, 1'b1), 10);
            begin
                repeat (156) @(posedge clk);
                #2;
                rd_en = 1'b1;
                @(posedge clk);
                #2;
                rd_en = 1'b0;
            end
        join
        model_frame({2'b00, 8'h14}, 1'b1);
        quiet = 1'b1;
        chk("sim_count", count, 4);
        chk("sim_overrun", overrun, 0);
        for (int i = 1; i <= 4; i++) pop(8'h10 + 8'(i));

        quiet = 1'b0;
        rx = 1'b0;
        repeat (12 * c_BIT) @(posedge clk);
        #2;
        rx = 1'b1;
        repeat (3 * c_BIT) @(posedge clk);
        #2;
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_pulses", brk_cnt, 1);
        chk("brk_nopush", empty, 1);
        quiet = 1'b1;
        rx_frame(8'h55, 1'b1);
        chk("post_brk_data", rd_data, 8'h55);
        pop(8'h55);
`else
        chk("brk_pulses", brk_cnt, 0);
        model_frame(10'h200, 1'b0);
        quiet = 1'b1;
        chk("brk_data", rd_data, 8'h00);
        chk("brk_fe", rd_frame_err, 1);
        pop(8'h00);
`endif

        send(1'b1, {5'b11111, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        chk("par_ok_err", rd_parity_err_p, 0);
        chk("par_ok_data", rd_data_p, 8'h07);
        chk("par_ok_count", count_p, 1);
        pop_p();
        send(1'b1, {5'b11111, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        chk("par_bad_err", rd_parity_err_p, 1);
        chk("par_bad_data", rd_data_p, 8'h07);
        pop_p();
        chk("par_empty", empty_p, 1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
